// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared types for the MEM-stage data-memory access unit:
//                access size encoding, access-unit FSM states and the
//                alignment predicate used by the unit and the control path.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } mau_state_t;

    // A halfword must sit on an even address, a word on a multiple of four.
    // The unused size code 2'b11 is treated like a word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            MEM_BYTE: mis = 1'b0;
            MEM_HALF: mis = addr_lo[0];
            default:  mis = |addr_lo;
        endcase
        return mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
//  Module      : load_align
//  Description : Combinational load formatter. Selects the addressed byte or
//                halfword lane of the memory read word and sign- or
//                zero-extends it to 32 bits; words pass straight through.
//  Revision    : 1.0  initial release
// ============================================================================
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        sign_bit;

    // Pick the addressed lane, then extend according to size and signedness.
    always_comb begin
        byte_lane = rdata_i[{addr_lo_i, 3'b000} +: 8];
        half_lane = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        sign_bit  = 1'b0;
        data_o    = rdata_i;
        case (size_i)
            MEM_BYTE: begin
                sign_bit = byte_lane[7] & ~unsigned_i;
                data_o   = {{24{sign_bit}}, byte_lane};
            end
            MEM_HALF: begin
                sign_bit = half_lane[15] & ~unsigned_i;
                data_o   = {{16{sign_bit}}, half_lane};
            end
            default: data_o = rdata_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : MEM-stage data-memory access unit. Turns ex_mem load/store
//                requests into a req/ack bus transaction, aborts on timeout,
//                flags misaligned accesses, stalls the pipeline until the
//                access completes and registers the formatted load word.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead_ex_mem,
    input  logic        MemWrite_ex_mem,
    input  logic [1:0]  mem_size_ex_mem,
    input  logic        mem_unsigned_ex_mem,
    input  logic [31:0] alu_out_ex_mem,
    input  logic [31:0] store_data_ex_mem,
    output logic [31:0] ram_read_data_mem,
    output logic        stall_mem,
    output logic        addr_err,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mau_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mem_req_q;
    logic             mem_we_q;
    logic [29:0]      mem_addr_q;
    logic [3:0]       mem_be_q;
    logic [31:0]      mem_wdata_q;
    logic             addr_err_q;
    logic             bus_err_q;
    logic [31:0]      rdata_q;

    // Access attributes captured in IDLE so formatting never looks at ex_mem later.
    logic [1:0]       size_q;
    logic [1:0]       addr_lo_q;
    logic             unsigned_q;
    logic             is_load_q;

    logic             access;
    logic             misaligned_d;
    logic [3:0]       be_d;
    logic [31:0]      wdata_d;
    logic [31:0]      load_word_d;

    assign access       = MemRead_ex_mem | MemWrite_ex_mem;
    assign misaligned_d = is_misaligned(mem_size_ex_mem, alu_out_ex_mem[1:0]);

    // Pipeline is held while an access is pending and released in DONE.
    assign stall_mem = access & (state_q != DONE);

    // Store lane placement: replicate the data and enable only the addressed lanes.
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = store_data_ex_mem;
        case (mem_size_ex_mem)
            MEM_BYTE: begin
                be_d    = 4'b0001 << alu_out_ex_mem[1:0];
                wdata_d = {4{store_data_ex_mem[7:0]}};
            end
            MEM_HALF: begin
                be_d    = alu_out_ex_mem[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{store_data_ex_mem[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = store_data_ex_mem;
            end
        endcase
    end

    load_align u_load_align (
        .rdata_i    (mem_rdata),
        .addr_lo_i  (addr_lo_q),
        .size_i     (size_q),
        .unsigned_i (unsigned_q),
        .data_o     (load_word_d)
    );

    // Access FSM with its timeout counter and all registered bus/pipeline outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            addr_err_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            rdata_q     <= '0;
            size_q      <= '0;
            addr_lo_q   <= '0;
            unsigned_q  <= 1'b0;
            is_load_q   <= 1'b0;
        end else begin
            // Error flags are single-cycle pulses visible only in DONE.
            addr_err_q <= 1'b0;
            bus_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (access) begin
                        size_q     <= mem_size_ex_mem;
                        addr_lo_q  <= alu_out_ex_mem[1:0];
                        unsigned_q <= mem_unsigned_ex_mem;
                        // A store always wins when both strobes are raised.
                        is_load_q  <= ~MemWrite_ex_mem;
                        if (misaligned_d) begin
                            rdata_q    <= '0;
                            addr_err_q <= 1'b1;
                            state_q    <= DONE;
                        end else begin
                            mem_addr_q  <= alu_out_ex_mem[31:2];
                            mem_we_q    <= MemWrite_ex_mem;
                            mem_be_q    <= be_d;
                            mem_wdata_q <= wdata_d;
                            mem_req_q   <= 1'b1;
                            cnt_q       <= '0;
                            state_q     <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        // An ack on the final counted cycle still completes normally.
                        mem_req_q <= 1'b0;
                        cnt_q     <= '0;
                        if (is_load_q) begin
                            rdata_q <= load_word_d;
                        end
                        state_q   <= DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        mem_req_q <= 1'b0;
                        cnt_q     <= '0;
                        rdata_q   <= '0;
                        bus_err_q <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign ram_read_data_mem = rdata_q;
    assign addr_err          = addr_err_q;
    assign bus_err           = bus_err_q;
    assign mem_req           = mem_req_q;
    assign mem_we            = mem_we_q;
    assign mem_addr          = mem_addr_q;
    assign mem_be            = mem_be_q;
    assign mem_wdata         = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Self-checking bench for mem_access_unit. Directed cases for
//                the documented examples plus randomized load/store traffic
//                with random ack latency, checked against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MemRead_ex_mem = 1'b0;
    logic        MemWrite_ex_mem = 1'b0;
    logic [1:0]  mem_size_ex_mem = 2'b00;
    logic        mem_unsigned_ex_mem = 1'b0;
    logic [31:0] alu_out_ex_mem = '0;
    logic [31:0] store_data_ex_mem = '0;
    logic [31:0] ram_read_data_mem;
    logic        stall_mem;
    logic        addr_err;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int checks = 0;
    int failures = 0;

    // Model state: the load result register only changes on completed loads or errors.
    logic [31:0] exp_data = '0;
    logic [3:0]  cap_be;
    logic [31:0] cap_wdata;
    logic [29:0] cap_addr;
    logic        cap_we;

    mem_access_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .MemRead_ex_mem      (MemRead_ex_mem),
        .MemWrite_ex_mem     (MemWrite_ex_mem),
        .mem_size_ex_mem     (mem_size_ex_mem),
        .mem_unsigned_ex_mem (mem_unsigned_ex_mem),
        .alu_out_ex_mem      (alu_out_ex_mem),
        .store_data_ex_mem   (store_data_ex_mem),
        .ram_read_data_mem   (ram_read_data_mem),
        .stall_mem           (stall_mem),
        .addr_err            (addr_err),
        .bus_err             (bus_err),
        .mem_req             (mem_req),
        .mem_we              (mem_we),
        .mem_addr            (mem_addr),
        .mem_be              (mem_be),
        .mem_wdata           (mem_wdata),
        .mem_ack             (mem_ack),
        .mem_rdata           (mem_rdata)
    );

    always #5 clk = ~clk;

    // Reference load formatting: shift the word so the addressed byte is at the bottom,
    // then extend arithmetically.
    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] a,
                                               input logic [1:0] sz, input logic uns);
        logic [31:0] s;
        s = w >> (8 * a[1:0]);
        if (sz == 2'd0) begin
            s = s & 32'h0000_00FF;
            if (!uns) s = (s ^ 32'h80) - 32'h80;
        end else if (sz == 2'd1) begin
            s = s & 32'h0000_FFFF;
            if (!uns) s = (s ^ 32'h8000) - 32'h8000;
        end else begin
            s = w;
        end
        return s;
    endfunction

    function automatic logic [3:0] model_be(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'd0) return 4'(1 << a[1:0]);
        if (sz == 2'd1) return 4'(3 << a[1:0]);
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] d, input logic [1:0] sz);
        if (sz == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    // One complete access starting at posedge+1 with the unit in IDLE; returns at
    // posedge+1 of the IDLE cycle after DONE. ack_dly < 0 means memory never answers.
    task automatic do_access(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                             input logic [31:0] addr, input logic [31:0] sd,
                             input int ack_dly, input logic [31:0] rdat);
        logic        mis;
        logic        tmo;
        logic        done_seen;
        int          stalls;
        int          reqc;
        int          exp_stalls;
        int          exp_reqc;
        logic [31:0] exp_rd;
        mis = (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'b00);
        tmo = !mis && (ack_dly < 0 || ack_dly >= T);
        exp_stalls = mis ? 1 : (tmo ? T + 1 : ack_dly + 2);
        exp_reqc   = mis ? 0 : (tmo ? T : ack_dly + 1);
        if (mis || tmo)  exp_rd = 32'h0;
        else if (wr)     exp_rd = exp_data;
        else             exp_rd = model_load(rdat, addr, sz, uns);

        MemRead_ex_mem      = rd;
        MemWrite_ex_mem     = wr;
        mem_size_ex_mem     = sz;
        mem_unsigned_ex_mem = uns;
        alu_out_ex_mem      = addr;
        store_data_ex_mem   = sd;
        stalls = 0;
        reqc = 0;
        done_seen = 1'b0;
        for (int cyc = 0; cyc < 64 && !done_seen; cyc++) begin
            #1;
            if (!stall_mem) begin
                done_seen = 1'b1;
            end else begin
                stalls++;
                if (mem_req) begin
                    checks++;
                    if (mem_addr !== addr[31:2]) begin
                        failures++;
                        $display("FAIL acc_addr: got %h expected %h (cycle %0d)", mem_addr, addr[31:2], reqc);
                    end
                    if (reqc == 0) begin
                        cap_be = mem_be; cap_wdata = mem_wdata; cap_addr = mem_addr; cap_we = mem_we;
                        checks++;
                        if (mem_we !== wr) begin
                            failures++;
                            $display("FAIL acc_we: got %b expected %b", mem_we, wr);
                        end
                        if (wr) begin
                            checks++;
                            if (mem_be !== model_be(addr, sz)) begin
                                failures++;
                                $display("FAIL acc_be: got %b expected %b", mem_be, model_be(addr, sz));
                            end
                            checks++;
                            if (mem_wdata !== model_wdata(sd, sz)) begin
                                failures++;
                                $display("FAIL acc_wdata: got %h expected %h", mem_wdata, model_wdata(sd, sz));
                            end
                        end
                    end
                    if (reqc == ack_dly) begin
                        mem_ack = 1'b1;
                        mem_rdata = rdat;
                    end
                    reqc++;
                end
                @(posedge clk);
                #1;
                mem_ack = 1'b0;
                mem_rdata = $urandom;
                // ex_mem contents must not matter once the access has been accepted.
                alu_out_ex_mem      = $urandom;
                store_data_ex_mem   = $urandom;
                mem_size_ex_mem     = 2'($urandom_range(0, 2));
                mem_unsigned_ex_mem = 1'($urandom);
            end
        end
        checks++;
        if (!done_seen) begin
            failures++;
            $display("FAIL acc_done: got no DONE within 64 cycles expected completion");
        end
        checks++;
        if (stalls != exp_stalls) begin
            failures++;
            $display("FAIL acc_stalls: got %0d expected %0d", stalls, exp_stalls);
        end
        checks++;
        if (reqc != exp_reqc) begin
            failures++;
            $display("FAIL acc_req_cycles: got %0d expected %0d", reqc, exp_reqc);
        end
        checks++;
        if (ram_read_data_mem !== exp_rd) begin
            failures++;
            $display("FAIL acc_rdata: got %h expected %h", ram_read_data_mem, exp_rd);
        end
        checks++;
        if (addr_err !== mis || bus_err !== tmo || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL acc_done_flags: got ae=%b be=%b req=%b expected ae=%b be=%b req=0",
                     addr_err, bus_err, mem_req, mis, tmo);
        end
        exp_data = exp_rd;
        @(posedge clk);
        #1;
        checks++;
        if (addr_err !== 1'b0 || bus_err !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL acc_pulse_clear: got ae=%b be=%b req=%b expected 0 0 0", addr_err, bus_err, mem_req);
        end
    endtask

    task automatic idle_inputs();
        MemRead_ex_mem = 1'b0;
        MemWrite_ex_mem = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || addr_err !== 1'b0 || bus_err !== 1'b0 ||
            stall_mem !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got req=%b we=%b ae=%b be=%b stall=%b expected all 0",
                     mem_req, mem_we, addr_err, bus_err, stall_mem);
        end
        checks++;
        if (mem_addr !== 30'h0 || mem_be !== 4'h0 || mem_wdata !== 32'h0 || ram_read_data_mem !== 32'h0) begin
            failures++;
            $display("FAIL reset_data: got addr=%h be=%h wd=%h rd=%h expected all 0",
                     mem_addr, mem_be, mem_wdata, ram_read_data_mem);
        end
        rst = 1'b0;
        exp_data = 32'h0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        do_access(1, 0, 2'd2, 0, 32'h100, 32'h0, 0, 32'hDEADBEEF);
        checks++;
        if (ram_read_data_mem !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL dir_lw: got %h expected DEADBEEF", ram_read_data_mem);
        end
        do_access(1, 0, 2'd0, 0, 32'h103, 32'h0, 1, 32'h80112233);
        checks++;
        if (ram_read_data_mem !== 32'hFFFFFF80) begin
            failures++;
            $display("FAIL dir_lb: got %h expected FFFFFF80", ram_read_data_mem);
        end
        do_access(1, 0, 2'd0, 1, 32'h103, 32'h0, 2, 32'h80112233);
        checks++;
        if (ram_read_data_mem !== 32'h00000080) begin
            failures++;
            $display("FAIL dir_lbu: got %h expected 00000080", ram_read_data_mem);
        end
        do_access(1, 0, 2'd1, 0, 32'h102, 32'h0, 0, 32'h80112233);
        checks++;
        if (ram_read_data_mem !== 32'hFFFF8011) begin
            failures++;
            $display("FAIL dir_lh: got %h expected FFFF8011", ram_read_data_mem);
        end
        do_access(1, 0, 2'd1, 1, 32'h102, 32'h0, 0, 32'h80112233);
        checks++;
        if (ram_read_data_mem !== 32'h00008011) begin
            failures++;
            $display("FAIL dir_lhu: got %h expected 00008011", ram_read_data_mem);
        end
        do_access(0, 1, 2'd0, 0, 32'h101, 32'h000000AB, 0, 32'h0);
        checks++;
        if (cap_be !== 4'b0010 || cap_wdata !== 32'hABABABAB || cap_we !== 1'b1 || cap_addr !== 30'h40) begin
            failures++;
            $display("FAIL dir_sb: got be=%b wd=%h we=%b addr=%h expected 0010 ABABABAB 1 40",
                     cap_be, cap_wdata, cap_we, cap_addr);
        end
        checks++;
        if (ram_read_data_mem !== 32'h00008011) begin
            failures++;
            $display("FAIL dir_sb_keep: got %h expected 00008011", ram_read_data_mem);
        end
        do_access(1, 0, 2'd2, 0, 32'h102, 32'h0, 0, 32'h12345678);
        do_access(1, 0, 2'd2, 0, 32'h100, 32'h0, -1, 32'h0);
        // Ack exactly on the last counted cycle is a success.
        do_access(1, 0, 2'd2, 0, 32'h104, 32'h0, T - 1, 32'hCAFEF00D);
        checks++;
        if (ram_read_data_mem !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL dir_late_ack: got %h expected CAFEF00D", ram_read_data_mem);
        end
        // Both strobes high behaves as a store.
        do_access(1, 1, 2'd1, 0, 32'h10A, 32'h0000BEEF, 0, 32'h11111111);
    endtask

    task automatic test_spurious_ack();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            mem_ack = 1'b1;
            mem_rdata = $urandom;
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            checks++;
            if (mem_req !== 1'b0 || stall_mem !== 1'b0 || ram_read_data_mem !== exp_data) begin
                failures++;
                $display("FAIL spurious_ack: got req=%b stall=%b rd=%h expected 0 0 %h",
                         mem_req, stall_mem, ram_read_data_mem, exp_data);
            end
        end
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            int          op;
            int          dly;
            int          pick;
            logic [1:0]  sz;
            logic [31:0] addr;
            op   = $urandom_range(0, 2);
            sz   = 2'($urandom_range(0, 2));
            addr = $urandom;
            if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
            pick = $urandom_range(0, 19);
            if (pick < 14)       dly = $urandom_range(0, 5);
            else if (pick < 16)  dly = T - 1;
            else if (pick < 18)  dly = -1;
            else                 dly = T;
            do_access(op != 1, op != 0, sz, 1'($urandom), addr, $urandom, dly, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                idle_inputs();
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        @(posedge clk);
        #1;
        MemRead_ex_mem  = 1'b1;
        mem_size_ex_mem = 2'd2;
        alu_out_ex_mem  = 32'h200;
        @(posedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_req_up: got %b expected 1", mem_req);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_async: got %b expected 0", mem_req);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_inputs();
        exp_data = 32'h0;
        mem_ack = 1'b1;
        mem_rdata = 32'h55AA55AA;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || stall_mem !== 1'b0 || ram_read_data_mem !== 32'h0) begin
            failures++;
            $display("FAIL rstmid_late_ack: got req=%b stall=%b rd=%h expected 0 0 0",
                     mem_req, stall_mem, ram_read_data_mem);
        end
        do_access(1, 0, 2'd2, 0, 32'h204, 32'h0, 0, 32'h0BADF00D);
    endtask

    task automatic test_back_to_back();
        do_access(1, 0, 2'd2, 0, 32'h300, 32'h0, 0, 32'h01020304);
        do_access(0, 1, 2'd1, 0, 32'h306, 32'h0000CDEF, 1, 32'h0);
        do_access(1, 0, 2'd0, 0, 32'h305, 32'h0, 0, 32'h0000F100);
        checks++;
        if (ram_read_data_mem !== 32'hFFFFFFF1) begin
            failures++;
            $display("FAIL b2b_lb: got %h expected FFFFFFF1", ram_read_data_mem);
        end
        do_access(1, 0, 2'd1, 0, 32'h301, 32'h0, 0, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500000");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_spurious_ack();
        test_back_to_back();
        test_random(150);
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
